// File: rtl/sga_ram_arbiter.sv
// Arbiter/sequencer sharing the single-port snake-body RAM between the move
// engine (read/write), the collision checker and the matrix renderer (reads).
module sga_ram_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int MV_BURST_MAX = 4
) (
  input  logic              clock,
  input  logic              restart_n,
  input  logic              hold,
  input  logic              mv_req,
  input  logic              mv_we,
  input  logic [ADDR_W-1:0] mv_addr,
  input  logic [DATA_W-1:0] mv_wdata,
  input  logic              col_req,
  input  logic [ADDR_W-1:0] col_addr,
  input  logic              rnd_req,
  input  logic [ADDR_W-1:0] rnd_addr,
  output logic              mv_gnt,
  output logic              col_gnt,
  output logic              rnd_gnt,
  output logic              mv_valid,
  output logic              col_valid,
  output logic              rnd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        db_state
);

  // Handshake: a requester raises *_req with its addr/data stable; the request
  // is taken at the edge ending an IDLE cycle, *_gnt pulses for the one ACCESS
  // cycle that follows, and reads get *_valid with rd_data one cycle later.
  // A req still high in IDLE after its grant is taken as a new request.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_MV  = 2'd0,
    OWN_COL = 2'd1,
    OWN_RND = 2'd2
  } owner_t;

  localparam logic [2:0] BURST_MAX = 3'(MV_BURST_MAX);

  state_t     state, state_nxt;
  owner_t     owner, win;
  logic       acc_read;
  logic [2:0] burst_cnt;
  logic       rr_ptr;
  logic       rd_pending;
  logic       mv_wins;
  logic       grant;

  // Winner selection: move first, unless its burst is spent and a reader waits.
  always_comb begin
    rd_pending = col_req | rnd_req;
    mv_wins    = mv_req && !((burst_cnt == BURST_MAX) && rd_pending);
    win        = OWN_MV;
    if (!mv_wins) begin
      if (col_req && rnd_req) win = rr_ptr ? OWN_RND : OWN_COL;
      else if (col_req)       win = OWN_COL;
      else                    win = OWN_RND;
    end
    grant = (state == ST_IDLE) && !hold && (mv_req || rd_pending);
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = acc_read ? ST_RESP : ST_IDLE;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      owner     <= OWN_MV;
      acc_read  <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      burst_cnt <= '0;
      rr_ptr    <= 1'b0;
    end else if (grant) begin
      owner    <= win;
      acc_read <= !((win == OWN_MV) && mv_we);
      ram_we   <= (win == OWN_MV) && mv_we;
      case (win)
        OWN_COL: ram_addr <= col_addr;
        OWN_RND: ram_addr <= rnd_addr;
        default: ram_addr <= mv_addr;
      endcase
      if (win == OWN_MV) begin
        ram_wdata <= mv_wdata;
        if (!rd_pending)                  burst_cnt <= '0;
        else if (burst_cnt != BURST_MAX)  burst_cnt <= burst_cnt + 3'd1;
      end else begin
        // Readers reset the move burst and hand the tie-break to the other reader.
        burst_cnt <= '0;
        rr_ptr    <= (win == OWN_COL);
      end
    end else begin
      ram_we <= 1'b0;
    end
  end

  always_comb begin
    mv_gnt    = (state == ST_ACCESS) && (owner == OWN_MV);
    col_gnt   = (state == ST_ACCESS) && (owner == OWN_COL);
    rnd_gnt   = (state == ST_ACCESS) && (owner == OWN_RND);
    mv_valid  = (state == ST_RESP)   && (owner == OWN_MV);
    col_valid = (state == ST_RESP)   && (owner == OWN_COL);
    rnd_valid = (state == ST_RESP)   && (owner == OWN_RND);
    rd_data   = ram_rdata;
    db_state  = state;
  end

endmodule
